// File: rtl/spdif_pkg.sv
// Shared constants and types for the S/PDIF subframe transmitter.
// Preamble patterns are listed first-half-cell-first (MSB goes out first).
package spdif_pkg;

  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  localparam int SLOT_V = 28;
  localparam int SLOT_U = 29;
  localparam int SLOT_C = 30;
  localparam int SLOT_P = 31;

  localparam int AUDIO_LSB_SLOT = 4;
  localparam int AUDIO_W        = 24;
  localparam int BLOCK_FRAMES   = 192;
  localparam int HC_PER_SUB     = 64;
  localparam int PREAMBLE_HC    = 8;

  typedef enum logic {
    PREAMBLE = 1'b0,
    PAYLOAD  = 1'b1
  } spdif_state_e;

  function automatic logic [7:0] preamble_pattern(input logic first_frame,
                                                  input logic first_sub);
    if (!first_sub) return PRE_W;
    else if (first_frame) return PRE_B;
    else return PRE_M;
  endfunction

endpackage

// File: rtl/spdif_bmc_encoder.sv
// Line-level generator: raw preamble half-cells (polarity fixed at the first
// half-cell) and biphase-mark coding for payload slots.
module spdif_bmc_encoder (
  input  logic clock,
  input  logic nreset,
  input  logic pre_en_i,
  input  logic pre_first_i,
  input  logic pre_bit_i,
  input  logic slot_bit_i,
  input  logic half_i,
  output logic level_o
);

  logic level_q, level_d;
  logic inv_q, inv_d;

  always_comb begin
    level_d = level_q;
    inv_d   = inv_q;
    if (pre_en_i) begin
      // The whole preamble is inverted when the line sat at 1 before it.
      if (pre_first_i) begin
        inv_d   = level_q;
        level_d = pre_bit_i ^ level_q;
      end else begin
        level_d = pre_bit_i ^ inv_q;
      end
    end else if (!half_i) begin
      level_d = ~level_q;
    end else begin
      level_d = level_q ^ slot_bit_i;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      level_q <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      inv_q   <= inv_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/spdif_frame_tx.sv
// S/PDIF frame transmitter: holding buffer, 64-half-cell subframe sequencer,
// block framing. Define SPDIF_CSTAT_EN to drive the C bit from cstat.
module spdif_frame_tx
  import spdif_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 2
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       cstat,
  output logic              serial_out,
  output logic              underrun,
  output spdif_state_e      dbg_state_o
);

  localparam int FRAME_W = 8;
  localparam int PAY_W   = 32 - AUDIO_LSB_SLOT;
  localparam int V_IDX   = SLOT_V - AUDIO_LSB_SLOT;
  localparam int U_IDX   = SLOT_U - AUDIO_LSB_SLOT;
  localparam int C_IDX   = SLOT_C - AUDIO_LSB_SLOT;
  localparam int P_IDX   = SLOT_P - AUDIO_LSB_SLOT;

  spdif_state_e       state_q, state_d;
  logic [5:0]         hc_q, hc_d;
  logic               sub_q, sub_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               buf_full_q, buf_full_d;
  logic [DATA_W-1:0]  buf_q, buf_d;
  logic               s_ready_q, s_ready_d;
  logic [PAY_W-1:0]   shreg_q, shreg_d;

  logic               unload, pre_en, pre_first, end_sf, shift_en;
  logic               xfer, last_sub, last_frame;
  logic               c_bit;
  logic [AUDIO_W-1:0] audio;
  logic [PAY_W-1:0]   payload;
  logic [7:0]         pattern;
  logic               pre_bit;

  // Subframe sequencer FSM: state register.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state_q <= PREAMBLE;
    else         state_q <= state_d;
  end

  // Subframe sequencer FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PREAMBLE: if (hc_q == 6'(PREAMBLE_HC - 1)) state_d = PAYLOAD;
      PAYLOAD:  if (hc_q == 6'(HC_PER_SUB - 1))  state_d = PREAMBLE;
    endcase
  end

  // Subframe sequencer FSM: outputs.
  always_comb begin
    unload    = 1'b0;
    pre_en    = 1'b0;
    pre_first = 1'b0;
    end_sf    = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      PREAMBLE: begin
        pre_en    = 1'b1;
        pre_first = (hc_q == 6'd0);
        unload    = (hc_q == 6'(PREAMBLE_HC - 1));
      end
      PAYLOAD: begin
        shift_en = hc_q[0];
        end_sf   = (hc_q == 6'(HC_PER_SUB - 1));
      end
    endcase
  end

  always_comb begin
    hc_d       = hc_q + 6'd1;
    last_sub   = (CHANNELS == 1) || sub_q;
    last_frame = (frame_q == FRAME_W'(BLOCK_FRAMES - 1));
    sub_d      = sub_q;
    frame_d    = frame_q;
    if (end_sf) begin
      sub_d = ~last_sub;
      if (last_sub) frame_d = last_frame ? '0 : frame_q + 1'b1;
    end
  end

  // Unload happens before a same-cycle transfer, so that transfer refills.
  always_comb begin
    xfer       = s_valid & s_ready_q;
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    if (unload) buf_full_d = 1'b0;
    if (xfer) begin
      buf_full_d = 1'b1;
      buf_d      = s_data;
    end
    s_ready_d = ~buf_full_d;
  end

`ifdef SPDIF_CSTAT_EN
  logic c_q, c_d, c_fresh;

  assign c_fresh = (frame_q < FRAME_W'(32)) ? cstat[frame_q[4:0]] : 1'b0;
  assign c_bit   = sub_q ? c_q : c_fresh;
  assign c_d     = (unload && !sub_q) ? c_fresh : c_q;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) c_q <= 1'b0;
    else         c_q <= c_d;
  end
`else
  logic cstat_unused;

  assign cstat_unused = ^cstat;
  assign c_bit        = 1'b0;
`endif

  // Payload word for slots 4..31; bit 0 is slot 4, shifted out LSB first.
  always_comb begin
    audio = '0;
    if (buf_full_q) audio[AUDIO_W-1 -: DATA_W] = buf_q;
    payload                 = '0;
    payload[AUDIO_W-1:0]    = audio;
    payload[V_IDX]          = ~buf_full_q;
    payload[U_IDX]          = 1'b0;
    payload[C_IDX]          = c_bit;
    payload[P_IDX]          = ^payload[C_IDX:0];
    shreg_d = shreg_q;
    if (unload)        shreg_d = payload;
    else if (shift_en) shreg_d = {1'b0, shreg_q[PAY_W-1:1]};
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      hc_q       <= '0;
      sub_q      <= 1'b0;
      frame_q    <= '0;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      s_ready_q  <= 1'b0;
      shreg_q    <= '0;
    end else begin
      hc_q       <= hc_d;
      sub_q      <= sub_d;
      frame_q    <= frame_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      s_ready_q  <= s_ready_d;
      shreg_q    <= shreg_d;
    end
  end

  assign pattern = preamble_pattern(frame_q == '0, !sub_q);
  assign pre_bit = pattern[3'd7 - hc_q[2:0]];

  spdif_bmc_encoder u_bmc (
    .clock       (clock),
    .nreset      (nreset),
    .pre_en_i    (pre_en),
    .pre_first_i (pre_first),
    .pre_bit_i   (pre_bit),
    .slot_bit_i  (shreg_q[0]),
    .half_i      (hc_q[0]),
    .level_o     (serial_out)
  );

  assign s_ready     = s_ready_q;
  assign underrun    = unload & ~buf_full_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spdif_frame_tx.sv
// Bench for spdif_frame_tx: line decoder plus buffer-level reference model.
module tb_spdif_frame_tx;
  import spdif_pkg::*;

  localparam int DW = 16;
  localparam int CH = 2;
  localparam logic [7:0] EXP_B = 8'hE8;
  localparam logic [7:0] EXP_M = 8'hE2;
  localparam logic [7:0] EXP_W = 8'hE4;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   cstat = '0;
  logic          serial_out;
  logic          underrun;
  spdif_state_e  dbg_state;

  always #5 clock = ~clock;

  spdif_frame_tx #(.DATA_W(DW), .CHANNELS(CH)) dut (
    .clock       (clock),
    .nreset      (nreset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .cstat       (cstat),
    .serial_out  (serial_out),
    .underrun    (underrun),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Expected word per subframe: [31:4] slot bits, [1:0] preamble (0=B,1=M,2=W).
  logic [31:0] exp_q[$];

  int            edge_n;
  logic          mdl_full;
  logic [DW-1:0] mdl_data;
  logic          mdl_ready;
  logic          prev_level;
  logic [63:0]   line_v;
  logic [31:0]   last_got;
  int            ur_cnt, cnt_b, cnt_v1, cnt_c1;

  task automatic mdl_clear();
    edge_n = 0; mdl_full = 1'b0; mdl_ready = 1'b0; prev_level = 1'b0;
    ur_cnt = 0; cnt_b = 0; cnt_v1 = 0; cnt_c1 = 0;
    exp_q.delete();
  endtask

  task automatic do_reset(input logic [31:0] cs);
    @(negedge clock);
    nreset = 1'b0; s_valid = 1'b0; cstat = cs;
    repeat (3) @(negedge clock);
    mdl_clear();
    nreset = 1'b1;
  endtask

  task automatic score_subframe();
    logic [7:0]  pre;
    logic [31:0] got, exp;
    logic        trans_ok;
    for (int i = 0; i < 8; i++) pre[7-i] = line_v[i];
    pre = pre ^ {8{prev_level}};
    got = '0;
    got[1:0] = (pre == EXP_B) ? 2'd0 : (pre == EXP_M) ? 2'd1 : (pre == EXP_W) ? 2'd2 : 2'd3;
    trans_ok = 1'b1;
    for (int s = 4; s < 32; s++) begin
      if (line_v[2*s] == line_v[2*s-1]) trans_ok = 1'b0;
      got[s] = line_v[2*s] ^ line_v[2*s+1];
    end
    prev_level = line_v[63];
    last_got = got;
    if (got[1:0] == 2'd0) cnt_b++;
    if (got[SLOT_V]) cnt_v1++;
    if (got[SLOT_C]) cnt_c1++;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL subframe_queue sf=%0d got=%h required=queued entry", edge_n / 64, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL subframe_word sf=%0d got=%h required=%h", edge_n / 64, got, exp);
      end
    end
    checks++;
    if (trans_ok !== 1'b1) begin
      errors++;
      $display("FAIL bmc_slot_edges sf=%0d got=%b required=1", edge_n / 64, trans_ok);
    end
  endtask

  // One half-cell: drive, model the edge, observe #1 later.
  task automatic step(input logic v, input logic [DW-1:0] d, output bit acc);
    int hc, sf, frame;
    logic [23:0] aud;
    logic vb, cb, pb;
    logic [1:0] pt;
    logic exp_ur;
    s_valid = v; s_data = d;
    @(posedge clock);
    hc  = edge_n % 64;
    acc = v && mdl_ready;
    if (hc == 7) begin
      sf    = edge_n / 64;
      frame = (sf / CH) % 192;
      aud   = mdl_full ? (24'(mdl_data) << (24 - DW)) : 24'h0;
      vb    = !mdl_full;
`ifdef SPDIF_CSTAT_EN
      cb = (frame < 32) ? cstat[frame] : 1'b0;
`else
      cb = 1'b0;
`endif
      pb = ^{cb, vb, aud};
      pt = (sf % CH != 0) ? 2'd2 : (frame == 0) ? 2'd0 : 2'd1;
      exp_q.push_back({pb, cb, 1'b0, vb, aud, 2'b00, pt});
      mdl_full = 1'b0;
    end
    if (acc) begin
      mdl_full = 1'b1;
      mdl_data = d;
    end
    mdl_ready = !mdl_full;
    #1;
    line_v[hc] = serial_out;
    if (underrun === 1'b1) ur_cnt++;
    checks++;
    if (s_ready !== mdl_ready) begin
      errors++;
      $display("FAIL s_ready edge=%0d got=%b required=%b", edge_n, s_ready, mdl_ready);
    end
    exp_ur = (hc == 6) && !mdl_full;
    checks++;
    if (underrun !== exp_ur) begin
      errors++;
      $display("FAIL underrun edge=%0d got=%b required=%b", edge_n, underrun, exp_ur);
    end
    if (hc == 63) score_subframe();
    edge_n++;
  endtask

  task automatic test_reset();
    @(negedge clock);
    nreset = 1'b0; s_valid = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({serial_out, s_ready, underrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=000", {serial_out, s_ready, underrun});
    end
    mdl_clear();
    nreset = 1'b1;
  endtask

  task automatic test_idle();
    bit acc;
    logic [7:0] pat;
    for (int i = 0; i < 128; i++) begin
      step(1'b0, '0, acc);
      if (i == 0) begin
        checks++;
        if (serial_out !== 1'b1) begin
          errors++;
          $display("FAIL first_half_cell got=%b required=1", serial_out);
        end
      end
      if (i == 7) begin
        for (int k = 0; k < 8; k++) pat[7-k] = line_v[k];
        checks++;
        if (pat !== 8'b1110_1000) begin
          errors++;
          $display("FAIL idle_preamble got=%b required=11101000", pat);
        end
      end
    end
    checks++;
    if (ur_cnt != 2 || cnt_v1 != 2) begin
      errors++;
      $display("FAIL idle_underrun got=%0d/%0d required=2/2", ur_cnt, cnt_v1);
    end
  endtask

  task automatic test_stream();
    bit acc;
    int k;
    logic [DW-1:0] smp [2];
    smp[0] = 16'h8001; smp[1] = 16'h0003;
    do_reset(32'h0);
    k = 0;
    for (int i = 0; i < 128; i++) begin
      step(k < 2, (k < 2) ? smp[k] : '0, acc);
      if (acc) k++;
      if (i == 63) begin
        checks++;
        if (last_got[12] !== 1'b1 || last_got[27] !== 1'b1 || $countones(last_got[27:4]) != 2 ||
            last_got[1:0] !== 2'd0) begin
          errors++;
          $display("FAIL ch0_slots got=%h required=slots 12,27 with B", last_got);
        end
      end
    end
    checks++;
    if (last_got[13:12] !== 2'b11 || $countones(last_got[27:4]) != 2 || last_got[1:0] !== 2'd2) begin
      errors++;
      $display("FAIL ch1_slots got=%h required=slots 12,13 with W", last_got);
    end
    checks++;
    if ($countones(last_got[31:4]) % 2 != 0) begin
      errors++;
      $display("FAIL ch1_parity got=%0d ones required=even", $countones(last_got[31:4]));
    end
  endtask

  task automatic test_random();
    bit acc;
    do_reset($urandom);
    for (int i = 0; i < 40 * 64; i++)
      step($urandom_range(0, 3) != 0, DW'($urandom), acc);
  endtask

  task automatic test_block();
    bit acc;
    int exp_c1;
    do_reset(32'h0000_0005);
    for (int i = 0; i < 193 * CH * 64; i++) step(1'b1, DW'($urandom), acc);
`ifdef SPDIF_CSTAT_EN
    exp_c1 = 3 * CH;
`else
    exp_c1 = 0;
`endif
    checks++;
    if (cnt_b != 2) begin
      errors++;
      $display("FAIL block_b_count got=%0d required=2", cnt_b);
    end
    checks++;
    if (cnt_v1 != 0 || ur_cnt != 0) begin
      errors++;
      $display("FAIL block_fed_valid got=%0d/%0d required=0/0", cnt_v1, ur_cnt);
    end
    checks++;
    if (cnt_c1 != exp_c1) begin
      errors++;
      $display("FAIL block_c_count got=%0d required=%0d", cnt_c1, exp_c1);
    end
  endtask

  task automatic test_unload_xfer();
    bit acc, acc7;
    int rdy_hi, ur_before;
    logic [DW-1:0] smp;
    smp = DW'($urandom) | 16'h0100;
    do_reset(32'h0);
    rdy_hi = 0; acc7 = 1'b0; ur_before = 0;
    for (int i = 0; i < 128; i++) begin
      step(i == 7, (i == 7) ? smp : '0, acc);
      if (i == 7) begin
        acc7 = acc;
        ur_before = ur_cnt;
      end
      if (i >= 7 && i < 71 && s_ready === 1'b1) rdy_hi++;
      if (i == 71) begin
        checks++;
        if (s_ready !== 1'b1) begin
          errors++;
          $display("FAIL unload_ready_rise got=%b required=1", s_ready);
        end
      end
    end
    checks++;
    if (acc7 !== 1'b1 || rdy_hi != 0) begin
      errors++;
      $display("FAIL unload_xfer_hold got=%b/%0d required=1/0", acc7, rdy_hi);
    end
    checks++;
    if (last_got[27:4] !== (24'(smp) << 8) || last_got[SLOT_V] !== 1'b0 || ur_cnt != ur_before) begin
      errors++;
      $display("FAIL unload_next_sf got=%h/%0d required=%h/%0d", last_got[27:4], ur_cnt,
               24'(smp) << 8, ur_before);
    end
  endtask

  task automatic test_reset_mid();
    bit acc;
    logic [7:0] pat;
    do_reset(32'h0);
    for (int i = 0; i < 34; i++) step(1'b1, DW'($urandom), acc);
    #2 nreset = 1'b0;
    #1;
    checks++;
    if ({serial_out, s_ready, underrun} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%b required=000", {serial_out, s_ready, underrun});
    end
    do_reset(32'h0);
    for (int i = 0; i < 64; i++) step(1'b0, '0, acc);
    for (int k = 0; k < 8; k++) pat[7-k] = line_v[k];
    checks++;
    if (pat !== 8'b1110_1000 || last_got[1:0] !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_restart got=%b required=11101000", pat);
    end
  endtask

  initial begin
    mdl_clear();
    last_got = '0;
    line_v = '0;
    test_reset();
    test_idle();
    test_stream();
    test_unload_xfer();
    test_random();
    test_reset_mid();
    test_block();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
